tff_seq_ctrl: RTL and testbench

TFF_SEQ_CTRL -- requirements
Module: tff_seq_ctrl

---
 rtl/tff_seq_ctrl_pkg.sv | 13 +
 rtl/tff_cell.sv | 20 ++
 rtl/tff_seq_ctrl.sv | 108 ++++++++++
 tb/tb_tff_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tff_seq_ctrl_pkg.sv
// Shared types and constants for the toggle-cell sequence controller.
package tff_seq_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with complementary outputs and async active-low reset.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/tff_seq_ctrl.sv
// Counting sequencer built from WIDTH toggle cells; the FSM only drives toggle enables.
// Optional down-count mode (extra dir input) is enabled by defining TFF_SEQ_CTRL_DOWN_EN.
module tff_seq_ctrl
  import tff_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
`ifdef TFF_SEQ_CTRL_DOWN_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_b
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_r;
  logic             dir_r;
  logic             dir_in;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] load_val;
  logic             terminal;
  logic             carry;

`ifdef TFF_SEQ_CTRL_DOWN_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  // Ripple toggle enables: up uses AND of lower Q bits, down uses AND of lower QB bits.
  always_comb begin
    step  = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step[i] = carry;
      carry   = carry & (dir_r ? ~count[i] : count[i]);
    end
  end

  assign load_val = dir_in ? limit : '0;
  assign terminal = dir_r ? (count == '0) : (count == limit_r);

  always_comb begin
    state_d = state_q;
    t       = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          // Toggle exactly the bits that differ from the load value.
          t       = count ^ load_val;
        end
      end
      RUN: begin
        if (terminal) begin
          state_d = DONE;
        end else if (pause) begin
          state_d = HOLD;
        end else begin
          t = step;
        end
      end
      HOLD: begin
        if (!pause) state_d = RUN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      limit_r <= '0;
      dir_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        limit_r <= limit;
        dir_r   <= dir_in;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (count[i]),
      .qb  (count_b[i])
    );
  end

  assign busy = (state_q == RUN) || (state_q == HOLD);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed self-checking bench for tff_seq_ctrl (down-mode vectors when TFF_SEQ_CTRL_DOWN_EN is set).
module tb_tff_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] limit;
  logic         pause;
`ifdef TFF_SEQ_CTRL_DOWN_EN
  logic         dir;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] count;
  logic [W-1:0] count_b;

  int n_cmp = 0;
  int n_err = 0;
  int edges;

  tff_seq_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .limit   (limit),
    .pause   (pause),
`ifdef TFF_SEQ_CTRL_DOWN_EN
    .dir     (dir),
`endif
    .busy    (busy),
    .done    (done),
    .count   (count),
    .count_b (count_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for the sampling edge; returns just after that edge.
  task automatic start_seq(input logic [W-1:0] lim);
    limit = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges after the start-sampling edge until done; bounded so a stuck DUT still finishes.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    limit = '0;
    pause = 1'b0;
`ifdef TFF_SEQ_CTRL_DOWN_EN
    dir   = 1'b0;
`endif
    #1;
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_count_b", 32'(count_b), 32'hF);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Basic count, limit=3
    start_seq(4'd3);
    check_eq("basic_c0", 32'(count), 32'd0);
    check_eq("basic_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("basic_cn", 32'(count), 32'(i));
      check_eq("basic_nodone", 32'(done), 32'd0);
    end
    tick();
    check_eq("basic_done", 32'(done), 32'd1);
    check_eq("basic_final", 32'(count), 32'd3);
    check_eq("basic_busy_done", 32'(busy), 32'd0);
    tick();
    check_eq("basic_pulse", 32'(done), 32'd0);
    check_eq("basic_hold", 32'(count), 32'd3);
    check_eq("basic_idle", 32'(busy), 32'd0);

    // Pause for 3 edges at count=2 with limit=6: 7 + 4 edges
    start_seq(4'd6);
    tick();
    tick();
    check_eq("pause_at2", 32'(count), 32'd2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("pause_hold", 32'(count), 32'd2);
      check_eq("pause_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0;
    tick();
    check_eq("pause_resume_noinc", 32'(count), 32'd2);
    wait_done(edges);
    check_eq("pause_latency", 32'(edges + 6), 32'd11);
    check_eq("pause_final", 32'(count), 32'd6);
    tick();

    // limit=0
    start_seq(4'd0);
    wait_done(edges);
    check_eq("lim0_latency", 32'(edges), 32'd1);
    check_eq("lim0_count", 32'(count), 32'd0);
    tick();

    // limit=F: no wrap
    start_seq(4'hF);
    wait_done(edges);
    check_eq("limF_latency", 32'(edges), 32'd16);
    check_eq("limF_count", 32'(count), 32'hF);
    tick();
    check_eq("limF_nowrap", 32'(count), 32'hF);
    check_eq("limF_count_b", 32'(count_b), 32'h0);

    // Pause on terminal edge, limit=2
    start_seq(4'd2);
    tick();
    tick();
    pause = 1'b1;
    tick();
    check_eq("coll_pause_done", 32'(done), 32'd1);
    check_eq("coll_pause_count", 32'(count), 32'd2);
    pause = 1'b0;
    tick();

    // Start pulsed mid-RUN is ignored, limit_r stays 5
    start_seq(4'd5);
    tick();
    start = 1'b1;
    limit = 4'd1;
    tick();
    check_eq("coll_start_count", 32'(count), 32'd2);
    check_eq("coll_start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    limit = 4'd0;
    wait_done(edges);
    check_eq("coll_start_latency", 32'(edges), 32'd4);
    check_eq("coll_start_final", 32'(count), 32'd5);
    tick();

    // Reset at count=5
    start_seq(4'd9);
    for (int i = 0; i < 5; i++) tick();
    check_eq("mid_at5", 32'(count), 32'd5);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_count", 32'(count), 32'h0);
    check_eq("mid_rst_count_b", 32'(count_b), 32'hF);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    tick();
    // start sampled on the first edge after release
    rst   = 1'b1;
    limit = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("post_rst_busy", 32'(busy), 32'd1);
    check_eq("post_rst_count", 32'(count), 32'd0);
    wait_done(edges);
    check_eq("post_rst_latency", 32'(edges), 32'd3);
    tick();

`ifdef TFF_SEQ_CTRL_DOWN_EN
    dir = 1'b1;
    start_seq(4'd5);
    dir = 1'b0;
    check_eq("down_c5", 32'(count), 32'd5);
    for (int i = 4; i >= 0; i--) begin
      tick();
      check_eq("down_cn", 32'(count), 32'(i));
    end
    tick();
    check_eq("down_done", 32'(done), 32'd1);
    check_eq("down_final", 32'(count), 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
